// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared opcode/sub-op constants, FSM encoding and branch decode helpers
// for the ID-stage branch resolution controller.
package branch_resolve_ctrl_pkg;

   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;

   localparam logic [4:0] RT_BLTZ   = 5'b00000;
   localparam logic [4:0] RT_BGEZ   = 5'b00001;
   localparam logic [4:0] RT_BLTZAL = 5'b10000;
   localparam logic [4:0] RT_BGEZAL = 5'b10001;

   localparam logic [4:0] LINK_REG  = 5'd31;

   typedef logic [2:0] br_state_t;
   localparam br_state_t ST_IDLE  = 3'd0;
   localparam br_state_t ST_WAIT  = 3'd1;
   localparam br_state_t ST_EVAL  = 3'd2;
   localparam br_state_t ST_DSLOT = 3'd3;
   localparam br_state_t ST_REDIR = 3'd4;

   function automatic logic is_regimm_br(input logic [4:0] rt);
      return (rt == RT_BLTZ) || (rt == RT_BGEZ) || (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
   endfunction

   function automatic logic is_branch(input logic [5:0] op, input logic [4:0] rt);
      return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGTZ) || (op == OP_BLEZ) ||
             ((op == OP_REGIMM) && is_regimm_br(rt));
   endfunction

   function automatic logic uses_rt(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

   function automatic logic is_link(input logic [5:0] op, input logic [4:0] rt);
      return (op == OP_REGIMM) && ((rt == RT_BLTZAL) || (rt == RT_BGEZAL));
   endfunction

   function automatic logic br_cond(input logic [5:0] op, input logic [4:0] rt,
                                    input logic [31:0] a, input logic [31:0] b);
      logic r;
      case (op)
         OP_BEQ:  r = (a == b);
         OP_BNE:  r = (a != b);
         OP_BGTZ: r = !a[31] && (a != 32'd0);
         OP_BLEZ: r = a[31] || (a == 32'd0);
         default: r = ((rt == RT_BGEZ) || (rt == RT_BGEZAL)) ? !a[31] : a[31];
      endcase
      return r;
   endfunction

endpackage

// File: rtl/branch_resolve_ctrl_br_hazard_chk.sv
// br_hazard_chk: flags a branch operand that is still being produced by EX
// (any GPR write) or by a load in MEM. Register $0 never hazards.
module br_hazard_chk
   import branch_resolve_ctrl_pkg::*;
(
   input  logic [5:0] i_op,
   input  logic [4:0] i_rs,
   input  logic [4:0] i_rt,
   input  logic       i_ex_wreg,
   input  logic [4:0] i_ex_waddr,
   input  logic       i_mem_load,
   input  logic [4:0] i_mem_waddr,
   output logic       o_hazard
);

   logic w_rs_hit;
   logic w_rt_hit;

   assign w_rs_hit = (i_rs != 5'd0) &&
                     ((i_ex_wreg && (i_ex_waddr == i_rs)) || (i_mem_load && (i_mem_waddr == i_rs)));

   // rt is a REGIMM sub-op for most branches, so it only matters for BEQ/BNE
   assign w_rt_hit = uses_rt(i_op) && (i_rt != 5'd0) &&
                     ((i_ex_wreg && (i_ex_waddr == i_rt)) || (i_mem_load && (i_mem_waddr == i_rt)));

   assign o_hazard = w_rs_hit || w_rt_hit;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: stalls ID on branch operand hazards, evaluates the branch,
// lets the delay slot flow, then redirects IF. Macro BR_STATS_EN adds outcome counters.
module branch_resolve_ctrl
   import branch_resolve_ctrl_pkg::*;
#(
   parameter int PC_W     = 32,
   parameter int LINK_OFF = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [PC_W-1:0] id_pc,
   input  logic [5:0]      id_op,
   input  logic [4:0]      id_rs,
   input  logic [4:0]      id_rt,
   input  logic [15:0]     id_imm,
   input  logic [31:0]     rs_data,
   input  logic [31:0]     rt_data,
   input  logic            ex_wreg,
   input  logic [4:0]      ex_waddr,
   input  logic            mem_load,
   input  logic [4:0]      mem_waddr,
   input  logic            ds_issued,
   input  logic            redir_ready,
   output logic            id_stall,
   output logic            redir_valid,
   output logic [PC_W-1:0] redir_pc,
   output logic            br_taken,
   output logic            link_we,
   output logic [PC_W-1:0] link_data,
   output logic            busy
`ifdef BR_STATS_EN
   ,
   output logic [31:0]     stat_taken,
   output logic [31:0]     stat_nottaken
`endif
);

   br_state_t         r_state;
   br_state_t         w_state_nxt;
   logic              w_latch;
   logic              w_hazard;
   logic              w_is_br;
   logic              w_cond;
   logic signed [17:0] w_off;
   logic [PC_W-1:0]   w_target;

   logic [5:0]        r_op;
   logic [4:0]        r_rt;
   logic [31:0]       r_a;
   logic [31:0]       r_b;
   logic [PC_W-1:0]   r_target;
   logic [PC_W-1:0]   r_link;
   logic              r_br_taken;
   logic              r_redir_valid;

   br_hazard_chk u_hazard (
      .i_op        (id_op),
      .i_rs        (id_rs),
      .i_rt        (id_rt),
      .i_ex_wreg   (ex_wreg),
      .i_ex_waddr  (ex_waddr),
      .i_mem_load  (mem_load),
      .i_mem_waddr (mem_waddr),
      .o_hazard    (w_hazard)
   );

   assign w_is_br  = is_branch(id_op, id_rt);
   assign w_off    = {id_imm, 2'b00};
   assign w_target = id_pc + PC_W'(4) + PC_W'(w_off);
   assign w_cond   = br_cond(r_op, r_rt, r_a, r_b);

   always_comb begin
      // NOTE: defaults first so no path through the case leaves a latch behind.
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      if (flush) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (id_valid && w_is_br) begin
                  if (w_hazard) begin
                     w_state_nxt = ST_WAIT;
                  end else begin
                     w_latch     = 1'b1;
                     w_state_nxt = ST_EVAL;
                  end
               end
            end
            ST_WAIT: begin
               if (!w_hazard) begin
                  w_latch     = 1'b1;
                  w_state_nxt = ST_EVAL;
               end
            end
            ST_EVAL:  w_state_nxt = w_cond ? ST_DSLOT : ST_IDLE;
            ST_DSLOT: if (ds_issued) w_state_nxt = ST_REDIR;
            ST_REDIR: if (r_redir_valid && redir_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_op          <= '0;
         r_rt          <= '0;
         r_a           <= '0;
         r_b           <= '0;
         r_target      <= '0;
         r_link        <= '0;
         r_br_taken    <= 1'b0;
         r_redir_valid <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values of the others.
         r_state       <= w_state_nxt;
         r_redir_valid <= (w_state_nxt == ST_REDIR);
         if (w_latch) begin
            r_op     <= id_op;
            r_rt     <= id_rt;
            r_a      <= rs_data;
            r_b      <= rt_data;
            r_target <= w_target;
            r_link   <= id_pc + PC_W'(LINK_OFF);
         end
         if ((r_state == ST_EVAL) && !flush) r_br_taken <= w_cond;
      end
   end

   // ID stays frozen in REDIR so the fall-through instruction cannot issue before IF is redirected
   assign id_stall    = ((r_state == ST_IDLE) && id_valid && w_is_br && !flush) ||
                        (r_state == ST_WAIT) || (r_state == ST_EVAL) || (r_state == ST_REDIR);
   assign redir_valid = r_redir_valid;
   assign redir_pc    = r_target;
   assign br_taken    = r_br_taken;
   assign link_we     = (r_state == ST_EVAL) && is_link(r_op, r_rt);
   assign link_data   = r_link;
   assign busy        = (r_state != ST_IDLE);

`ifdef BR_STATS_EN
   logic [31:0] r_stat_taken;
   logic [31:0] r_stat_nottaken;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_taken    <= '0;
         r_stat_nottaken <= '0;
      end else if ((r_state == ST_EVAL) && !flush) begin
         if (w_cond) r_stat_taken    <= r_stat_taken + 32'd1;
         else        r_stat_nottaken <= r_stat_nottaken + 32'd1;
      end
   end

   assign stat_taken    = r_stat_taken;
   assign stat_nottaken = r_stat_nottaken;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios plus randomized
// branches against a transaction-level reference model.
module tb_branch_resolve_ctrl;

   logic        clk = 1'b0;
   logic        rst, flush, id_valid;
   logic [31:0] id_pc;
   logic [5:0]  id_op;
   logic [4:0]  id_rs, id_rt;
   logic [15:0] id_imm;
   logic [31:0] rs_data, rt_data;
   logic        ex_wreg, mem_load, ds_issued, redir_ready;
   logic [4:0]  ex_waddr, mem_waddr;
   logic        id_stall, redir_valid, br_taken, link_we, busy;
   logic [31:0] redir_pc, link_data;
`ifdef BR_STATS_EN
   logic [31:0] stat_taken, stat_nottaken;
`endif

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_st_taken = 0;
   logic [31:0] exp_st_nt = 0;

   branch_resolve_ctrl #(.PC_W(32), .LINK_OFF(8)) dut (
      .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
      .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_imm(id_imm),
      .rs_data(rs_data), .rt_data(rt_data), .ex_wreg(ex_wreg), .ex_waddr(ex_waddr),
      .mem_load(mem_load), .mem_waddr(mem_waddr), .ds_issued(ds_issued),
      .redir_ready(redir_ready), .id_stall(id_stall), .redir_valid(redir_valid),
      .redir_pc(redir_pc), .br_taken(br_taken), .link_we(link_we),
      .link_data(link_data), .busy(busy)
`ifdef BR_STATS_EN
      , .stat_taken(stat_taken), .stat_nottaken(stat_nottaken)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Reference model: architectural branch semantics on signed values
   function automatic bit ref_taken(input logic [5:0] op, input logic [4:0] rtf,
                                    input logic [31:0] a, input logic [31:0] b);
      case (op)
         6'd4:    return a == b;
         6'd5:    return a != b;
         6'd7:    return $signed(a) > 0;
         6'd6:    return $signed(a) <= 0;
         default: return (rtf == 5'd1 || rtf == 5'd17) ? ($signed(a) >= 0) : ($signed(a) < 0);
      endcase
   endfunction

   function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] imm);
      int off;
      off = $signed(imm);
      return pc + 32'd4 + 32'(off * 4);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0; id_valid = 0; id_pc = 0; id_op = 0; id_rs = 0; id_rt = 0; id_imm = 0;
      rs_data = 0; rt_data = 0; ex_wreg = 0; ex_waddr = 0; mem_load = 0; mem_waddr = 0;
      ds_issued = 0; redir_ready = 0;
   endtask

   task automatic check_stats(input string tag);
`ifdef BR_STATS_EN
      checks++;
      if (stat_taken !== exp_st_taken) begin
         errors++; $display("FAIL %s stat_taken got=%0d exp=%0d", tag, stat_taken, exp_st_taken);
      end
      checks++;
      if (stat_nottaken !== exp_st_nt) begin
         errors++; $display("FAIL %s stat_nottaken got=%0d exp=%0d", tag, stat_nottaken, exp_st_nt);
      end
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   // One full branch transaction: h hazard cycles, d DSLOT cycles before ds_issued,
   // r REDIR cycles before redir_ready.
   task automatic run_branch(input string tag, input logic [5:0] op, input logic [4:0] rsr,
                             input logic [4:0] rtf, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] pc, input logic [15:0] imm, input int h,
                             input bit haz_rt, input int d, input int r);
      bit          used_rt = (op == 6'd4 || op == 6'd5);
      logic [4:0]  hreg    = haz_rt ? rtf : rsr;
      int          eff_h   = (h > 0 && hreg != 5'd0 && (!haz_rt || used_rt)) ? h : 0;
      bit          tk      = ref_taken(op, rtf, a, b);
      bit          al      = (op == 6'd1 && (rtf == 5'd16 || rtf == 5'd17));
      logic [31:0] tgt     = ref_target(pc, imm);
      id_valid = 1; id_op = op; id_rs = rsr; id_rt = rtf; id_imm = imm; id_pc = pc;
      for (int c = 0; c <= eff_h; c++) begin
         ex_wreg = (c < h) && !haz_rt; ex_waddr = rsr;
         mem_load = (c < h) && haz_rt; mem_waddr = rtf;
         rs_data = (c < eff_h) ? ~a : a;
         rt_data = (c < eff_h) ? ~b : b;
         #1;
         checks++;
         if (id_stall !== 1'b1) begin errors++; $display("FAIL %s stall cyc%0d got=%b exp=1", tag, c, id_stall); end
         checks++;
         if (busy !== (c > 0)) begin errors++; $display("FAIL %s busy cyc%0d got=%b exp=%b", tag, c, busy, c > 0); end
         step();
      end
      ex_wreg = 0; mem_load = 0; rs_data = $urandom; rt_data = $urandom;
      #1;
      checks++;
      if (id_stall !== 1'b1) begin errors++; $display("FAIL %s eval stall got=%b exp=1", tag, id_stall); end
      checks++;
      if (link_we !== al) begin errors++; $display("FAIL %s eval link_we got=%b exp=%b", tag, link_we, al); end
      checks++;
      if (link_data !== pc + 32'd8) begin errors++; $display("FAIL %s link_data got=%h exp=%h", tag, link_data, pc + 32'd8); end
      checks++;
      if (redir_valid !== 1'b0) begin errors++; $display("FAIL %s eval redir_valid got=%b exp=0", tag, redir_valid); end
      step();
      if (tk) exp_st_taken++; else exp_st_nt++;
      if (tk) begin
         // delay-slot instruction looks like a hazarded BEQ and must still flow
         id_valid = 1; id_op = 6'd4; id_rs = 5'd3; id_rt = 5'd3; ex_wreg = 1; ex_waddr = 5'd3;
      end else begin
         id_valid = 0;
      end
      #1;
      checks++;
      if (br_taken !== tk) begin errors++; $display("FAIL %s br_taken got=%b exp=%b", tag, br_taken, tk); end
      checks++;
      if (link_we !== 1'b0) begin errors++; $display("FAIL %s link_we post-eval got=%b exp=0", tag, link_we); end
      if (!tk) begin
         checks++;
         if (busy !== 1'b0 || id_stall !== 1'b0 || redir_valid !== 1'b0) begin
            errors++; $display("FAIL %s not-taken idle got busy=%b stall=%b rv=%b exp all 0", tag, busy, id_stall, redir_valid);
         end
         return;
      end
      for (int c = 0; c <= d; c++) begin
         ds_issued = (c == d);
         #1;
         checks++;
         if (id_stall !== 1'b0 || busy !== 1'b1 || redir_valid !== 1'b0) begin
            errors++; $display("FAIL %s dslot cyc%0d got stall=%b busy=%b rv=%b exp 0/1/0", tag, c, id_stall, busy, redir_valid);
         end
         step();
      end
      ds_issued = 0; id_valid = 0; ex_wreg = 0;
      for (int c = 0; c <= r; c++) begin
         redir_ready = (c == r);
         #1;
         checks++;
         if (redir_valid !== 1'b1) begin errors++; $display("FAIL %s redir cyc%0d valid got=%b exp=1", tag, c, redir_valid); end
         checks++;
         if (redir_pc !== tgt) begin errors++; $display("FAIL %s redir_pc got=%h exp=%h", tag, redir_pc, tgt); end
         step();
      end
      redir_ready = 0;
      #1;
      checks++;
      if (redir_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL %s after handshake got rv=%b busy=%b exp 0/0", tag, redir_valid, busy);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      #1;
      checks++;
      if ({id_stall, redir_valid, br_taken, link_we, busy} !== 5'b0 || redir_pc !== 0 || link_data !== 0) begin
         errors++; $display("FAIL reset outputs got stall=%b rv=%b tk=%b lw=%b busy=%b pc=%h ld=%h exp all 0",
                            id_stall, redir_valid, br_taken, link_we, busy, redir_pc, link_data);
      end
      check_stats("reset");
      step(); step();
      rst = 0;
      step();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset release busy got=%b exp=0", busy); end
   endtask

   task automatic test_non_branch();
      logic [5:0] ops [4] = '{6'd0, 6'd8, 6'd2, 6'd1};
      for (int i = 0; i < 4; i++) begin
         id_valid = 1; id_op = ops[i]; id_rt = 5'd2; id_rs = 5'd4; ex_wreg = 1; ex_waddr = 5'd4;
         #1;
         checks++;
         if (id_stall !== 1'b0) begin errors++; $display("FAIL nonbr op%0d stall got=%b exp=0", ops[i], id_stall); end
         step();
         checks++;
         if (busy !== 1'b0) begin errors++; $display("FAIL nonbr op%0d busy got=%b exp=0", ops[i], busy); end
      end
      idle_inputs();
   endtask

   task automatic test_directed();
      run_branch("beq_taken", 6'd4, 5'd5, 5'd6, 32'd5, 32'd5, 32'h1000, 16'h0004, 0, 0, 1, 3);
      run_branch("bne_haz", 6'd5, 5'd8, 5'd9, 32'd1, 32'd2, 32'h2000, 16'h0010, 2, 0, 0, 0);
      run_branch("bgezal_nt", 6'd1, 5'd7, 5'd17, 32'h80000000, 32'd0, 32'h3000, 16'h0020, 0, 0, 0, 0);
      run_branch("bltzal_tk", 6'd1, 5'd7, 5'd16, 32'h80000000, 32'd0, 32'h3100, 16'hFFFF, 1, 0, 0, 1);
      run_branch("blez_wrap", 6'd6, 5'd2, 5'd0, 32'd0, 32'd0, 32'h00000004, 16'h8000, 0, 0, 0, 0);
      checks++;
      if (ref_target(32'h4, 16'h8000) !== 32'hFFFE0008 || redir_pc !== 32'hFFFE0008) begin
         errors++; $display("FAIL blez_wrap redir_pc got=%h exp=fffe0008", redir_pc);
      end
      run_branch("r0_nohaz", 6'd7, 5'd0, 5'd0, 32'd0, 32'd0, 32'h4000, 16'h0001, 2, 0, 0, 0);
      run_branch("beq_rt_haz", 6'd4, 5'd3, 5'd12, 32'h55, 32'h55, 32'h5000, 16'h0100, 1, 1, 0, 0);
      run_branch("bgtz_rt_ignored", 6'd7, 5'd3, 5'd0, 32'd9, 32'd0, 32'h6000, 16'h0002, 2, 1, 2, 0);
      check_stats("directed");
   endtask

   task automatic test_random();
      logic [5:0] ops [8] = '{6'd4, 6'd5, 6'd7, 6'd6, 6'd1, 6'd1, 6'd1, 6'd1};
      logic [4:0] sub [8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd16, 5'd17};
      for (int i = 0; i < 30; i++) begin
         int          k  = $urandom_range(0, 7);
         logic [31:0] a  = $urandom;
         logic [31:0] b  = $urandom;
         logic [4:0]  rt = (k < 2) ? 5'($urandom_range(0, 31)) : sub[k];
         if ($urandom_range(0, 3) == 0) b = a;
         if ($urandom_range(0, 7) == 0) a = 32'd0;
         run_branch($sformatf("rnd%0d", i), ops[k], 5'($urandom_range(0, 31)), rt, a, b,
                    {$urandom, 2'b00}, 16'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), $urandom_range(0, 2));
      end
      check_stats("random");
   endtask

   task automatic test_flush_redir();
      id_valid = 1; id_op = 6'd4; id_rs = 5'd1; id_rt = 5'd2; rs_data = 32'd7; rt_data = 32'd7;
      id_pc = 32'h7000; id_imm = 16'h0008;
      step();                 // -> EVAL
      step();                 // -> DSLOT
      exp_st_taken++;
      id_valid = 0; ds_issued = 1;
      step();                 // -> REDIR
      ds_issued = 0; redir_ready = 0;
      #1;
      checks++;
      if (redir_valid !== 1'b1) begin errors++; $display("FAIL flush pre redir_valid got=%b exp=1", redir_valid); end
      flush = 1;
      step();
      flush = 0;
      checks++;
      if (redir_valid !== 1'b0 || busy !== 1'b0 || id_stall !== 1'b0) begin
         errors++; $display("FAIL flush redir got rv=%b busy=%b stall=%b exp 0/0/0", redir_valid, busy, id_stall);
      end
      check_stats("flush");
   endtask

   task automatic test_reset_mid();
      id_valid = 1; id_op = 6'd4; id_rs = 5'd1; id_rt = 5'd2; rs_data = 32'd3; rt_data = 32'd3;
      id_pc = 32'h8000; id_imm = 16'h0004;
      step();                 // -> EVAL
      step();                 // -> DSLOT
      id_valid = 0;
      #1;
      checks++;
      if (busy !== 1'b1 || br_taken !== 1'b1) begin errors++; $display("FAIL rstmid pre busy=%b tk=%b exp 1/1", busy, br_taken); end
      rst = 1;
      exp_st_taken = 0; exp_st_nt = 0;
      #1;
      checks++;
      if ({id_stall, redir_valid, br_taken, link_we, busy} !== 5'b0 || redir_pc !== 0 || link_data !== 0) begin
         errors++; $display("FAIL rstmid outputs got stall=%b rv=%b tk=%b lw=%b busy=%b pc=%h ld=%h exp all 0",
                            id_stall, redir_valid, br_taken, link_we, busy, redir_pc, link_data);
      end
      check_stats("rstmid");
      step();
      rst = 0;
      step();
      checks++;
      if (busy !== 1'b0 || redir_valid !== 1'b0) begin errors++; $display("FAIL rstmid after busy=%b rv=%b exp 0/0", busy, redir_valid); end
   endtask

   initial begin
      test_reset();
      test_non_branch();
      test_directed();
      idle_inputs();
      test_random();
      idle_inputs();
      test_flush_redir();
      idle_inputs();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
